alu_seq_ctrl: RTL and testbench

//  Board-side sequencer for the combinational ALU (8-bit signed data, 6-bit funct-style op).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 30 +++
 rtl/btn_edge.sv | 22 ++
 rtl/alu_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, sequencer state encoding, opcode legality helper.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // True when the opcode is one the ALU implements.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
      default:                                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: two's complement add/sub, bitwise logic, arithmetic/logical right shifts.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_res
);

  // Select the operation; unsupported codes produce zero (the sequencer never issues them).
  always_comb begin
    o_res = {NB_DATA{1'b0}};
    case (i_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_NOR:  o_res = ~(i_a | i_b);
      OP_SRA:  o_res = $unsigned($signed(i_a) >>> i_b);
      OP_SRL:  o_res = i_a >> i_b;
      default: o_res = {NB_DATA{1'b0}};
    endcase
  end

endmodule

// File: rtl/btn_edge.sv
// One-bit rising-edge pulse generator for a debounced, already-synchronous button.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_btn_q;

  // Remember last cycle's button level so a held button yields a single pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= i_btn;
    end
  end

  assign o_pulse = i_btn & ~r_btn_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Board-side sequencer: loads A, B and OP from the switch bus on button presses,
// rejects unsupported opcodes, runs the ALU and registers the result for display.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_STATE = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NB_DATA-1:0]  i_sw,
  input  logic                i_btn_a,
  input  logic                i_btn_b,
  input  logic                i_btn_op,
  input  logic                i_btn_clr,
  output logic [NB_DATA-1:0]  o_result,
  output logic                o_valid,
  output logic                o_err,
  output logic [NB_STATE-1:0] o_state
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NB_DATA-1:0]   r_a, r_b, r_result;
  logic [NB_DATA-1:0]   w_a_nxt, w_b_nxt, w_result_nxt;
  logic [NB_OP-1:0]     r_op, w_op_nxt;
  logic                 r_valid, r_err, w_valid_nxt, w_err_nxt;
  logic                 w_pulse_a, w_pulse_b, w_pulse_op, w_pulse_clr;
  logic [NB_DATA-1:0]   w_alu_res;
  logic [NB_OP-1:0]     w_sw_op;

  assign w_sw_op = i_sw[NB_OP-1:0];

  btn_edge u_edge_a   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_a),   .o_pulse(w_pulse_a));
  btn_edge u_edge_b   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_b),   .o_pulse(w_pulse_b));
  btn_edge u_edge_op  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op),  .o_pulse(w_pulse_op));
  btn_edge u_edge_clr (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_clr), .o_pulse(w_pulse_clr));

  alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_res(w_alu_res)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath updates; clear outranks every other button, and
  // only the button belonging to the current state has any effect.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_valid_nxt  = r_valid;
    w_err_nxt    = r_err;
    if (w_pulse_clr) begin
      w_state_nxt  = ST_A;
      w_a_nxt      = {NB_DATA{1'b0}};
      w_b_nxt      = {NB_DATA{1'b0}};
      w_op_nxt     = {NB_OP{1'b0}};
      w_result_nxt = {NB_DATA{1'b0}};
      w_valid_nxt  = 1'b0;
      w_err_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_A: begin
          if (w_pulse_a) begin
            w_a_nxt     = i_sw;
            w_state_nxt = ST_B;
          end else begin
            w_state_nxt = ST_A;
          end
        end
        ST_B: begin
          if (w_pulse_b) begin
            w_b_nxt     = i_sw;
            w_state_nxt = ST_OP;
          end else begin
            w_state_nxt = ST_B;
          end
        end
        ST_OP: begin
          if (w_pulse_op) begin
            if (is_legal_op(w_sw_op)) begin
              w_op_nxt    = w_sw_op;
              w_err_nxt   = 1'b0;
              w_state_nxt = ST_EXEC;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_OP;
            end
          end else begin
            w_state_nxt = ST_OP;
          end
        end
        ST_EXEC: begin
          w_result_nxt = w_alu_res;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = ST_DONE;
        end
        ST_DONE: begin
          if (w_pulse_a) begin
            w_a_nxt     = i_sw;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_B;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          w_state_nxt = ST_A;
        end
      endcase
    end
  end

  // Operand, opcode and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a      <= {NB_DATA{1'b0}};
      r_b      <= {NB_DATA{1'b0}};
      r_op     <= {NB_OP{1'b0}};
      r_result <= {NB_DATA{1'b0}};
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_state  = NB_STATE'(r_state);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: results go through a scoreboard queue checked
// by a monitor on each rising o_valid; state/flag checks are made inline.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op, btn_clr;
  logic [7:0] result;
  logic       valid, err;
  logic [2:0] state;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  alu_seq_ctrl dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sw     (sw),
    .i_btn_a  (btn_a),
    .i_btn_b  (btn_b),
    .i_btn_op (btn_op),
    .i_btn_clr(btn_clr),
    .o_result (result),
    .o_valid  (valid),
    .o_err    (err),
    .o_state  (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_result: got %0h expected none", result);
      end else begin
        check("result", {24'h0, result}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_valid = valid;
  end

  // Press one button for a single cycle with the given switch value.
  task automatic press(input int which, input logic [7:0] val);
    @(negedge clk);
    sw = val;
    case (which)
      0: btn_a = 1'b1;
      1: btn_b = 1'b1;
      2: btn_op = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0; btn_clr = 1'b0;
  endtask

  // Full transaction with a legal opcode; checks the one-cycle EXEC latency.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] exp_res);
    press(0, a);
    press(1, b);
    check("state_op", {29'h0, state}, 32'd2);
    exp_q.push_back(exp_res);
    @(negedge clk);
    sw = op; btn_op = 1'b1;
    @(negedge clk);
    btn_op = 1'b0;
    check("state_exec", {29'h0, state}, 32'd3);
    check("valid_in_exec", {31'h0, valid}, 32'd0);
    @(negedge clk);
    check("valid_done", {31'h0, valid}, 32'd1);
    check("state_done", {29'h0, state}, 32'd4);
    check("err_done", {31'h0, err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'h00;
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0; btn_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_state", {29'h0, state}, 32'd0);
    check("rst_valid", {31'h0, valid}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_result", {24'h0, result}, 32'h0);

    // Basic add, subtract with negative operand, signed wrap.
    run_op(8'h05, 8'h03, 8'h20, 8'h08);
    press(0, 8'hFD);
    check("new_txn_valid_clr", {31'h0, valid}, 32'd0);
    check("new_txn_state", {29'h0, state}, 32'd1);
    check("new_txn_result_hold", {24'h0, result}, 32'h08);
    press(1, 8'h05);
    exp_q.push_back(8'hF8);
    press(2, 8'h22);
    @(negedge clk);
    check("sub_state", {29'h0, state}, 32'd4);
    run_op(8'h7F, 8'h01, 8'h20, 8'h80);

    // Illegal opcode then a legal AND.
    press(0, 8'hF0);
    press(1, 8'h3C);
    press(2, 8'h3F);
    check("illegal_err", {31'h0, err}, 32'd1);
    check("illegal_state", {29'h0, state}, 32'd2);
    check("illegal_valid", {31'h0, valid}, 32'd0);
    exp_q.push_back(8'h30);
    press(2, 8'h24);
    check("legal_err_clr", {31'h0, err}, 32'd0);
    @(negedge clk);
    check("and_state", {29'h0, state}, 32'd4);

    // Held button gives one load; B ignored in ST_A.
    press(3, 8'h00);
    check("clr_state", {29'h0, state}, 32'd0);
    press(1, 8'h99);
    check("b_ignored_in_a", {29'h0, state}, 32'd0);
    @(negedge clk);
    sw = 8'h11; btn_a = 1'b1;
    repeat (5) @(negedge clk);
    btn_a = 1'b0;
    check("hold_a_state", {29'h0, state}, 32'd1);
    press(1, 8'h22);
    exp_q.push_back(8'h33);
    press(2, 8'h20);
    @(negedge clk);
    check("hold_result_state", {29'h0, state}, 32'd4);

    // Clear in ST_OP with err set, and clear together with op.
    press(0, 8'h01);
    press(1, 8'h02);
    press(2, 8'h3F);
    check("pre_clr_err", {31'h0, err}, 32'd1);
    press(3, 8'h00);
    check("clr_op_state", {29'h0, state}, 32'd0);
    check("clr_op_err", {31'h0, err}, 32'd0);
    check("clr_op_valid", {31'h0, valid}, 32'd0);
    check("clr_op_result", {24'h0, result}, 32'h0);
    press(0, 8'h01);
    press(1, 8'h02);
    @(negedge clk);
    sw = 8'h20; btn_op = 1'b1; btn_clr = 1'b1;
    @(negedge clk);
    btn_op = 1'b0; btn_clr = 1'b0;
    check("clr_with_op_state", {29'h0, state}, 32'd0);
    repeat (2) @(negedge clk);
    check("clr_with_op_valid", {31'h0, valid}, 32'd0);
    check("clr_with_op_state2", {29'h0, state}, 32'd0);

    // Reset while in ST_DONE, then shifts.
    run_op(8'h05, 8'h03, 8'h20, 8'h08);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_result", {24'h0, result}, 32'h0);
    check("mid_rst_valid", {31'h0, valid}, 32'd0);
    check("mid_rst_state", {29'h0, state}, 32'd0);
    run_op(8'h80, 8'h02, 8'h03, 8'hE0);
    run_op(8'h80, 8'h02, 8'h02, 8'h20);
    run_op(8'hAA, 8'h0F, 8'h27, 8'h50);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
